// File: rtl/serial_vector_builder_pkg.sv
// Shared constants for the serial-to-vector builder: FSM state encoding and default word width.
package serial_vector_builder_pkg;

  localparam logic ST_COLLECT    = 1'b0;
  localparam logic ST_HOLD       = 1'b1;
  localparam int   DEFAULT_WIDTH = 4;

  typedef enum logic {
    COLLECT = ST_COLLECT,
    HOLD    = ST_HOLD
  } state_t;

endpackage

// File: rtl/serial_vector_builder_vec_reduce_flags.sv
// Pure combinational AND/OR/XOR reductions over a WIDTH-bit vector.
module vec_reduce_flags #(
  parameter int WIDTH = serial_vector_builder_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] vec,
  output logic             vec_and,
  output logic             vec_or,
  output logic             vec_xor
);

  assign vec_and = &vec;
  assign vec_or  = |vec;
  assign vec_xor = ^vec;

endmodule

// File: rtl/serial_vector_builder.sv
// Assembles an LSB-first serial bit stream into WIDTH-bit words with registered reduction flags.
module serial_vector_builder
  import serial_vector_builder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   idx, idx_n;
  logic [WIDTH-1:0]   shreg, shreg_n;
  logic [WIDTH-1:0]   next_word;
  logic [WIDTH-1:0]   vec_n;
  logic               and_n, or_n, xor_n, overrun_n;
  logic               word_and, word_or, word_xor;
  logic               last_bit;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);
  assign last_bit  = (idx == CNT_W'(WIDTH - 1));

  // Partial word with the incoming bit merged at position idx.
  always_comb begin
    next_word = shreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == CNT_W'(i)) begin
        next_word[i] = in_bit;
      end else begin
        next_word[i] = shreg[i];
      end
    end
  end

  vec_reduce_flags #(.WIDTH(WIDTH)) u_flags (
    .vec     (next_word),
    .vec_and (word_and),
    .vec_or  (word_or),
    .vec_xor (word_xor)
  );

  // Next-state, index, shift register and output-register loads; clr beats a completing bit.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    shreg_n   = shreg;
    vec_n     = out_vec;
    and_n     = out_and;
    or_n      = out_or;
    xor_n     = out_xor;
    overrun_n = overrun | (in_valid & ~in_ready);
    case (state)
      COLLECT: begin
        if (clr) begin
          idx_n   = '0;
          shreg_n = '0;
        end else if (in_valid) begin
          if (last_bit) begin
            vec_n   = next_word;
            and_n   = word_and;
            or_n    = word_or;
            xor_n   = word_xor;
            idx_n   = '0;
            shreg_n = '0;
            state_n = HOLD;
          end else begin
            shreg_n = next_word;
            idx_n   = idx + CNT_W'(1);
          end
        end else begin
          idx_n   = idx;
          shreg_n = shreg;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n = COLLECT;
        end else begin
          state_n = HOLD;
        end
      end
      default: begin
        state_n = COLLECT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      idx     <= '0;
      shreg   <= '0;
      out_vec <= '0;
      out_and <= 1'b0;
      out_or  <= 1'b0;
      out_xor <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      out_vec <= vec_n;
      out_and <= and_n;
      out_or  <= or_n;
      out_xor <= xor_n;
      overrun <= overrun_n;
    end
  end

endmodule

// File: tb/tb_serial_vector_builder.sv
// Table-driven directed bench for serial_vector_builder (WIDTH=4) plus an async-reset sequence.
module tb_serial_vector_builder;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_bit, out_ready;
  logic       in_ready, out_valid, out_and, out_or, out_xor, overrun;
  logic [3:0] out_vec;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       v, b, c, r;
    logic       ev;
    logic [3:0] evec;
    logic       ea, eo, ex, eov;
  } vec_t;

  vec_t tbl[$];

  serial_vector_builder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_and   (out_and),
    .out_or    (out_or),
    .out_xor   (out_xor),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [3:0] evec,
                         input logic ea, input logic eo, input logic ex, input logic eov);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(!ev));
    chk({tag, ".out_vec"},   32'(out_vec),   32'(evec));
    chk({tag, ".out_and"},   32'(out_and),   32'(ea));
    chk({tag, ".out_or"},    32'(out_or),    32'(eo));
    chk({tag, ".out_xor"},   32'(out_xor),   32'(ex));
    chk({tag, ".overrun"},   32'(overrun),   32'(eov));
  endtask

  task automatic add(input logic v, input logic b, input logic c, input logic r,
                     input logic ev, input logic [3:0] evec,
                     input logic ea, input logic eo, input logic ex, input logic eov);
    vec_t t;
    t.v = v; t.b = b; t.c = c; t.r = r;
    t.ev = ev; t.evec = evec; t.ea = ea; t.eo = eo; t.ex = ex; t.eov = eov;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic v, input logic b, input logic c, input logic r);
    in_valid = v; in_bit = b; clr = c; out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    //  v     b     c     r     ev    vec      and   or    xor   ovr
    // stream 1,0,1,1 with out_ready high
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101, 1'b0, 1'b1, 1'b1, 1'b0);
    // stream 1,1,1,1 held for four cycles with out_ready low
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    // 1,1 then clr (with a discarded 1) then 0,0,0,0
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    // 0,1,1,0 into HOLD, then a bit while in HOLD sets overrun
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1);
    // next word comes only from bits after hand-off: 1,0,0,0
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1);
    // clr in HOLD leaves the pending word alone
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1);

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk_all("reset", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].b, tbl[i].c, tbl[i].r);
      step();
      chk_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].evec,
              tbl[i].ea, tbl[i].eo, tbl[i].ex, tbl[i].eov);
    end

    // three accepted bits, then asynchronous reset mid-cycle
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) step();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    #1 rst_n = 1'b1;
    step();

    // 0,1,0,0 after reset yields 4'b0010
    drive(1'b1, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 1'b1, 1'b0, 1'b1); step();
    drive(1'b1, 1'b0, 1'b0, 1'b1); step();
    chk("post_rst.no_early_word", 32'(out_valid), 32'(1'b0));
    drive(1'b1, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    waited = 0;
    while (!out_valid && waited < 8) begin
      step();
      waited++;
    end
    chk("post_rst.wait_bound", 32'(waited), 32'(0));
    chk_all("post_rst", 1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk("post_rst.release", 32'(in_ready), 32'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
